// File: rtl/display_scheduler_pkg.sv
// Shared constants, FSM state type and the round-robin helper for the
// display scheduler.
package display_scheduler_pkg;

  localparam int unsigned BIN_W      = 32;
  localparam int unsigned BCD_DIGITS = 10;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
  localparam int unsigned IDX_W      = 3;
  localparam logic [3:0]  MODE_DASH  = 4'ha;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    SHOW
  } state_t;

  // First asserted request searching upward from last+1, wrapping at n.
  // Only meaningful when at least one of the low n request bits is set.
  function automatic logic [IDX_W-1:0] rr_next(input logic [7:0]       req,
                                               input logic [IDX_W-1:0] last,
                                               input int unsigned      n);
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] idx;
    logic             found;
    win   = last;
    found = 1'b0;
    for (int unsigned k = 1; k <= n; k++) begin
      idx = IDX_W'((32'(last) + k) % n);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/display_scheduler_if.sv
// Requester-side handshake bundle: level requests with value/mode payload,
// one-cycle ack pulses back from the scheduler.
interface display_scheduler_if
  import display_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ = 3
);

  logic [N_REQ-1:0]       req;
  logic [BIN_W*N_REQ-1:0] req_value;
  logic [4*N_REQ-1:0]     req_mode;
  logic [N_REQ-1:0]       ack;

  modport master (
    output req,
    output req_value,
    output req_mode,
    input  ack
  );

  modport slave (
    input  req,
    input  req_value,
    input  req_mode,
    output ack
  );

endinterface

// File: rtl/display_scheduler_bin_to_bcd_step.sv
// One combinational double-dabble iteration: add 3 to every BCD digit >= 5,
// then shift {bcd, bin} left by one bit.
module display_scheduler_bin_to_bcd_step
  import display_scheduler_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic [BCD_W-1:0] bcd_o,
  output logic [BIN_W-1:0] bin_o
);

  logic [BCD_W-1:0]       adj;
  logic [BCD_W+BIN_W-1:0] shifted;

  always_comb begin
    adj = bcd_i;
    for (int unsigned d = 0; d < BCD_DIGITS; d++) begin
      if (bcd_i[4*d +: 4] >= 4'd5) begin
        adj[4*d +: 4] = bcd_i[4*d +: 4] + 4'd3;
      end
    end
    shifted = {adj, bin_i} << 1;
  end

  assign bcd_o = shifted[BCD_W+BIN_W-1:BIN_W];
  assign bin_o = shifted[BIN_W-1:0];

endmodule

// File: rtl/display_scheduler.sv
// Round-robin display sharer: grants one requester, converts its value to
// BCD over 32 cycles, then holds the committed result for HOLD_CYCLES.
module display_scheduler
  import display_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ       = 3,
  parameter int unsigned HOLD_CYCLES = 2097152
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  display_scheduler_if.slave req_if,
  output logic [BCD_W-1:0]   bcd_o,
  output logic [3:0]         mode_o,
  output logic               en_o,
  output logic               busy_o
);

  state_t           state_q, state_d;
  logic [4:0]       iter_q, iter_d;
  logic [31:0]      hold_q, hold_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] acc_q, acc_d;
  logic [3:0]       wmode_q, wmode_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [3:0]       mode_q, mode_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic [N_REQ-1:0] ack_q, ack_d;

  logic [BCD_W-1:0] step_bcd;
  logic [BIN_W-1:0] step_bin;
  logic [IDX_W-1:0] win;

  display_scheduler_bin_to_bcd_step u_step (
    .bcd_i (acc_q),
    .bin_i (bin_q),
    .bcd_o (step_bcd),
    .bin_o (step_bin)
  );

  assign win = rr_next(8'(req_if.req), ptr_q, N_REQ);

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    hold_d  = hold_q;
    ptr_d   = ptr_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    wmode_d = wmode_q;
    bcd_d   = bcd_q;
    mode_d  = mode_q;
    en_d    = en_q;
    busy_d  = busy_q;
    ack_d   = '0;

    unique case (state_q)
      IDLE: begin
        if (|req_if.req) begin
          ptr_d   = win;
          bin_d   = req_if.req_value[BIN_W*win +: BIN_W];
          wmode_d = req_if.req_mode[4*win +: 4];
          acc_d   = '0;
          iter_d  = '0;
          for (int unsigned i = 0; i < N_REQ; i++) begin
            ack_d[i] = (win == IDX_W'(i));
          end
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        acc_d  = step_bcd;
        bin_d  = step_bin;
        iter_d = iter_q + 5'd1;
        // The last iteration's result goes straight to the outputs so the
        // display never sees the accumulator mid-conversion.
        if (iter_q == 5'd31) begin
          bcd_d   = step_bcd;
          mode_d  = wmode_q;
          en_d    = 1'b1;
          hold_d  = 32'(HOLD_CYCLES - 1);
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (hold_q == '0) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          hold_d = hold_q - 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear overrides any grant taken above, including the pointer update.
    if (clear_i) begin
      state_d = IDLE;
      ptr_d   = ptr_q;
      ack_d   = '0;
      busy_d  = 1'b0;
      bcd_d   = '0;
      mode_d  = MODE_DASH;
      en_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      iter_q  <= '0;
      hold_q  <= '0;
      ptr_q   <= IDX_W'(N_REQ - 1);
      bin_q   <= '0;
      acc_q   <= '0;
      wmode_q <= MODE_DASH;
      bcd_q   <= '0;
      mode_q  <= MODE_DASH;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      wmode_q <= wmode_d;
      bcd_q   <= bcd_d;
      mode_q  <= mode_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
    end
  end

  assign req_if.ack = ack_q;
  assign bcd_o      = bcd_q;
  assign mode_o     = mode_q;
  assign en_o       = en_q;
  assign busy_o     = busy_q;

endmodule
